// File: rtl/mux8_sweep_ctrl.sv
// rtl/mux8_sweep_ctrl.sv - 8:1 mux select sequencer sweeping row elements over a job of rows.
// Optional stall counter output enabled by MUX8_SWEEP_STALL_CNT_EN.
module mux8_sweep_ctrl #(
  parameter int MAX_ROWS  = 8,
  parameter int START_SEL = 0,
  localparam int ROW_W    = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       row_len,
  input  logic [ROW_W:0]   num_rows,
  input  logic             out_ready,
  output logic [2:0]       switch,
  output logic [ROW_W-1:0] row_idx,
  output logic             out_valid,
  output logic             out_last_elem,
  output logic             out_last_row,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
`ifdef MUX8_SWEEP_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [2:0]     SEL0     = 3'(START_SEL);
  localparam logic [ROW_W:0] ROWS_ONE = (ROW_W+1)'(1);
  localparam logic [ROW_W:0] ROWS_MAX = (ROW_W+1)'(MAX_ROWS);

  state_t           r_state;
  logic [3:0]       r_len;
  logic [3:0]       r_elem;
  logic [ROW_W:0]   r_rows;

  logic             w_beat;
  logic             w_cfg_ok;
  logic             w_accept;
  logic [3:0]       w_elem_nxt;
  logic [ROW_W-1:0] w_row_nxt;

  assign w_beat     = out_valid & out_ready;
  assign w_cfg_ok   = (row_len != 4'd0) && (row_len <= 4'd8) &&
                      (num_rows != '0) && (num_rows <= ROWS_MAX);
  assign w_accept   = (r_state == S_IDLE) && start && w_cfg_ok;
  assign w_elem_nxt = r_elem + 4'd1;
  assign w_row_nxt  = row_idx + ROW_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_len         <= 4'd0;
      r_elem        <= 4'd0;
      r_rows        <= '0;
      switch        <= SEL0;
      row_idx       <= '0;
      out_valid     <= 1'b0;
      out_last_elem <= 1'b0;
      out_last_row  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (w_cfg_ok) begin
              r_len         <= row_len;
              r_rows        <= num_rows;
              r_elem        <= 4'd0;
              switch        <= SEL0;
              row_idx       <= '0;
              out_valid     <= 1'b1;
              out_last_elem <= (row_len == 4'd1);
              out_last_row  <= (num_rows == ROWS_ONE);
              busy          <= 1'b1;
              r_state       <= S_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_beat) begin
            if (out_last_elem) begin
              switch <= SEL0;
              r_elem <= 4'd0;
              if (out_last_row) begin
                out_valid     <= 1'b0;
                out_last_elem <= 1'b0;
                out_last_row  <= 1'b0;
                done          <= 1'b1;
                r_state       <= S_DONE;
              end else begin
                row_idx       <= w_row_nxt;
                out_last_elem <= (r_len == 4'd1);
                out_last_row  <= ({1'b0, w_row_nxt} == (r_rows - ROWS_ONE));
              end
            end else begin
              // Last-element flag comes from the element count, since switch wraps mod 8
              switch        <= switch + 3'd1;
              r_elem        <= w_elem_nxt;
              out_last_elem <= (w_elem_nxt == (r_len - 4'd1));
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MUX8_SWEEP_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (w_accept) begin
      stall_cnt <= 16'd0;
    end else if ((r_state == S_RUN) && out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux8_sweep_ctrl.sv
// tb/tb_mux8_sweep_ctrl.sv - randomized bench for mux8_sweep_ctrl against a beat-queue model.
module tb_mux8_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, out_ready;
  logic [3:0] row_len;
  logic [3:0] num_rows;

  logic [2:0] a_switch, b_switch;
  logic [2:0] a_row, b_row;
  logic       a_valid, a_le, a_lr, a_busy, a_done, a_err;
  logic       b_valid, b_le, b_lr, b_busy, b_done, b_err;
`ifdef MUX8_SWEEP_STALL_CNT_EN
  logic [15:0] a_stall, b_stall;
`endif

  always #5 clk = ~clk;

  mux8_sweep_ctrl #(.MAX_ROWS(8), .START_SEL(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .row_len(row_len), .num_rows(num_rows),
    .out_ready(out_ready), .switch(a_switch), .row_idx(a_row), .out_valid(a_valid),
    .out_last_elem(a_le), .out_last_row(a_lr), .busy(a_busy), .done(a_done), .cfg_err(a_err)
`ifdef MUX8_SWEEP_STALL_CNT_EN
    , .stall_cnt(a_stall)
`endif
  );

  mux8_sweep_ctrl #(.MAX_ROWS(8), .START_SEL(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .row_len(row_len), .num_rows(num_rows),
    .out_ready(out_ready), .switch(b_switch), .row_idx(b_row), .out_valid(b_valid),
    .out_last_elem(b_le), .out_last_row(b_lr), .busy(b_busy), .done(b_done), .cfg_err(b_err)
`ifdef MUX8_SWEEP_STALL_CNT_EN
    , .stall_cnt(b_stall)
`endif
  );

  typedef struct {
    int elem;
    int row;
    bit le;
    bit lr;
  } beat_t;

  // Model: a job is the list of beats still owed; phase 0 idle, 1 streaming, 2 done cycle
  beat_t m_q[$];
  int    m_phase;
  bit    m_cfg;
  bit    m_fresh;
  int    m_stall;
  int    n_checks = 0;
  int    n_err    = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit st, input int len, input int nr, input bit rdy, input bit rn);
    if (!rn) begin
      m_phase = 0; m_q.delete(); m_cfg = 0; m_fresh = 1; m_stall = 0;
    end else if (m_phase == 0) begin
      if (st) begin
        if (len >= 1 && len <= 8 && nr >= 1 && nr <= 8) begin
          for (int r = 0; r < nr; r++)
            for (int e = 0; e < len; e++)
              m_q.push_back('{e, r, e == len - 1, r == nr - 1});
          m_phase = 1; m_fresh = 0; m_stall = 0;
        end else begin
          m_cfg = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_phase = 2;
      end else if (m_stall < 65535) begin
        m_stall++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_outputs();
    bit v;
    int e_row, e_le, e_lr;
    v = (m_phase == 1);
    chk("valid_a", a_valid, v);
    chk("valid_b", b_valid, v);
    chk("busy_a", a_busy, m_phase != 0);
    chk("busy_b", b_busy, m_phase != 0);
    chk("done_a", a_done, m_phase == 2);
    chk("done_b", b_done, m_phase == 2);
    chk("cfg_err_a", a_err, m_cfg);
    chk("cfg_err_b", b_err, m_cfg);
    chk("switch_a", a_switch, v ? (m_q[0].elem % 8) : 0);
    chk("switch_b", b_switch, v ? ((6 + m_q[0].elem) % 8) : 6);
    if (v || m_fresh) begin
      e_row = v ? m_q[0].row : 0;
      e_le  = v ? m_q[0].le : 0;
      e_lr  = v ? m_q[0].lr : 0;
      chk("row_idx_a", a_row, e_row);
      chk("row_idx_b", b_row, e_row);
      chk("last_elem_a", a_le, e_le);
      chk("last_elem_b", b_le, e_le);
      chk("last_row_a", a_lr, e_lr);
      chk("last_row_b", b_lr, e_lr);
    end
`ifdef MUX8_SWEEP_STALL_CNT_EN
    chk("stall_cnt_a", a_stall, m_stall);
    chk("stall_cnt_b", b_stall, m_stall);
`endif
  endtask

  task automatic step(input bit st, input int len, input int nr, input bit rdy, input bit rn);
    start     = st;
    row_len   = 4'(len);
    num_rows  = 4'(nr);
    out_ready = rdy;
    rst_n     = rn;
    model_update(st, len, nr, rdy, rn);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; row_len = 4'd0; num_rows = 4'd0;
    m_phase = 0; m_cfg = 0; m_fresh = 1; m_stall = 0;
    @(negedge clk);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // 4 x 2 sweep at full rate
    step(1, 4, 2, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

    // 3 x 1 sweep: second instance wraps 6,7,0
    step(1, 3, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);

    // 8 x 1 with ready pattern 1,0,0 repeating
    step(1, 8, 1, 1, 1);
    for (int i = 0; i < 30; i++) step(0, 0, 0, (i % 3) == 0, 1);

    // illegal configurations, then a legal job
    step(1, 0, 2, 1, 1);
    step(1, 4, 9, 1, 1);
    step(0, 0, 0, 1, 1);
    step(1, 2, 2, 1, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1);

    // reset in the middle of row 1, then a fresh job
    step(0, 0, 0, 1, 0);
    step(1, 3, 2, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
    step(1, 3, 2, 1, 0);
    step(0, 0, 0, 1, 1);
    step(1, 3, 2, 1, 1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 1);

    // start pulses while busy are ignored; exactly one done
    dones = 0;
    step(1, 2, 3, 1, 1);
    for (int i = 0; i < 12; i++) begin
      step(1, 5, 5, (i % 2) == 0, 1);
      if (a_done) dones++;
      if (!a_busy) break;
    end
    chk("one_done", dones, 1);
    step(0, 0, 0, 1, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9), $urandom_range(0, 9),
           $urandom_range(0, 9) < 7, $urandom_range(0, 299) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mux8_sweep_ctrl.md
Name: mux8_sweep_ctrl

Overview:
- Sequencer that drives the 3-bit select of the 8:1 float mux so matrix-row elements stream serially, one per accepted beat, into a downstream consumer (MAC/accumulator).
- Sweeps a programmable element count per row over a programmable number of rows.
- Produces valid/last/row-index sideband and a done pulse.
- Control only; the real-valued data path stays in the mux.

Parameters:
- MAX_ROWS, 8, maximum rows per job; sets ROW_W = $clog2(MAX_ROWS), minimum 1.
- START_SEL, 0, first select value of every row (0..7).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  job request; accepted only in IDLE.
- row_len  input  4  elements per row, 1..8; sampled on accepted start.
- num_rows  input  ROW_W+1  rows in job, 1..MAX_ROWS; sampled on accepted start.
- out_ready  input  1  downstream accepts the current element.
- switch  output  3  select to the 8:1 mux.
- row_idx  output  ROW_W  current row number, 0-based.
- out_valid  output  1  switch/row_idx present a valid element.
- out_last_elem  output  1  current element is the last of its row.
- out_last_row  output  1  current row is the last of the job.
- busy  output  1  high when not IDLE.
- done  output  1  one-cycle pulse at job end.
- cfg_err  output  1  sticky; set by a start with illegal config.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; switch=START_SEL; row_idx=0; out_valid=0; out_last_elem=0; out_last_row=0; busy=0; done=0; cfg_err=0. Reset mid-job aborts immediately with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 with row_len in 1..8 and num_rows in 1..MAX_ROWS: latch both, set switch=START_SEL, set row_idx=0, go to RUN. out_valid is 1 on the next cycle.
  - On start=1 with row_len=0, row_len>8, num_rows=0 or num_rows>MAX_ROWS: set cfg_err=1 and stay in IDLE.
  - cfg_err clears only on reset.
- RUN:
  - out_valid=1 throughout.
  - Beat = out_valid & out_ready. No beat: all outputs hold.
  - Beat, not last element: switch <= switch+1, wrapping mod 8 (START_SEL=5, len 4 gives 5,6,7,0).
  - Beat on last element: switch <= START_SEL. If not the last row, row_idx <= row_idx+1.
  - out_last_elem = (element count == latched row_len-1). This is an element counter, not a switch compare.
  - out_last_row = (row_idx == latched num_rows-1).
  - Beat with both last flags set: go to DONE; out_valid=0 next cycle.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. start is ignored while busy, including in DONE.
- Throughput: one element per cycle when out_ready is held high. Latency from accepted start to first valid is 1 cycle. Job length is row_len*num_rows beats, plus 1 start cycle and 1 DONE cycle.
- Outputs are registered; no combinational path from out_ready to any output.

Optional Feature:
- Macro: MUX8_SWEEP_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits.
  - Cleared on accepted start and on reset.
  - Increments each RUN cycle with out_valid=1 and out_ready=0; saturates at 16'hFFFF.
  - Holds its value after DONE.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start, row_len=4, num_rows=2, out_ready=1 → switch 0,1,2,3,0,1,2,3; row_idx 0,0,0,0,1,1,1,1; out_last_elem on beats 4 and 8; done pulses exactly one cycle after beat 8.
- START_SEL=6, row_len=3, num_rows=1 → switch 6,7,0; out_last_elem and out_last_row on the third beat.
- row_len=8, num_rows=1, out_ready toggling 1,0,0,1,… → switch holds during low cycles; 8 beats total; with the macro defined, stall_cnt equals the count of ready-low cycles.
- start with row_len=0, then start with num_rows=MAX_ROWS+1 → cfg_err=1, busy stays 0, no out_valid. A following legal start runs normally and cfg_err stays 1.
- Mid-job (row 1, beat 2), assert rst_n=0 for one cycle → next cycle all outputs at reset values, no done. A fresh start sweeps from switch=START_SEL, row_idx=0.
- Pulse start repeatedly during RUN and DONE → ignored; the job completes unchanged and only one done pulse occurs.
